// File: rtl/red_pitaya_fads_pkg.sv
// Shared types and default widths for the FADS droplet sorter: detector and
// pulse-generator state encodings.
package red_pitaya_fads_pkg;

    localparam int FADS_WW = 16;  // droplet width counter / limits
    localparam int FADS_DW = 24;  // delay and pulse length
    localparam int FADS_CW = 32;  // event counters

    typedef enum logic {
        D_IDLE = 1'b0,
        D_IN   = 1'b1
    } det_state_e;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_DELAY = 2'd1,
        P_FIRE  = 2'd2
    } pg_state_e;

endpackage

// File: rtl/red_pitaya_fads_sorter_if.sv
// Link between the droplet detector and the pulse generator: sort request
// with its timing parameters one way, pulse and status counters the other.
interface red_pitaya_fads_sorter_if #(
    parameter int DW = 24,
    parameter int CW = 32
);
    // decision is a one-cycle strobe with no back-pressure; delay and pulse_len
    // qualify it in the same cycle. An idle slave accepts it, a busy one counts it missed.
    logic          decision;
    logic [DW-1:0] delay;
    logic [DW-1:0] pulse_len;
    logic          sort_trig;
    logic          busy;
    logic [CW-1:0] sorted_cnt;
    logic [CW-1:0] missed_cnt;

    modport master (
        output decision, delay, pulse_len,
        input  sort_trig, busy, sorted_cnt, missed_cnt
    );

    modport slave (
        input  decision, delay, pulse_len,
        output sort_trig, busy, sorted_cnt, missed_cnt
    );
endinterface

// File: rtl/red_pitaya_fads_pulse_gen.sv
// Turns accepted sort decisions into one delayed, fixed-length trigger pulse
// and counts issued pulses and decisions dropped while busy.
module red_pitaya_fads_pulse_gen
    import red_pitaya_fads_pkg::*;
#(
    parameter int DW = FADS_DW,
    parameter int CW = FADS_CW
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    red_pitaya_fads_sorter_if.slave    trig_if
);

    pg_state_e     state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] len_q, len_d;
    logic [CW-1:0] sorted_q, sorted_d;
    logic [CW-1:0] missed_q, missed_d;
    logic [DW-1:0] req_len;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= P_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            sorted_q <= '0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            sorted_q <= sorted_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        sorted_d = sorted_q;
        missed_d = missed_q;
        // A zero length would give no pulse at all, so it is stretched to one cycle.
        req_len  = (trig_if.pulse_len == '0) ? DW'(1) : trig_if.pulse_len;

        unique case (state_q)
            P_IDLE: begin
                if (trig_if.decision) begin
                    len_d = req_len;
                    if (trig_if.delay == '0) begin
                        state_d  = P_FIRE;
                        cnt_d    = req_len;
                        sorted_d = sorted_q + 1'b1;
                    end else begin
                        state_d = P_DELAY;
                        cnt_d   = trig_if.delay;
                    end
                end
            end
            P_DELAY: begin
                if (cnt_q == DW'(1)) begin
                    state_d  = P_FIRE;
                    cnt_d    = len_q;
                    sorted_d = sorted_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            P_FIRE: begin
                if (cnt_q == DW'(1)) begin
                    state_d = P_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = P_IDLE;
        endcase

        // Includes the edge on which FIRE returns to IDLE.
        if ((state_q != P_IDLE) && trig_if.decision) begin
            missed_d = missed_q + 1'b1;
        end
    end

    assign trig_if.sort_trig  = (state_q == P_FIRE);
    assign trig_if.busy       = (state_q != P_IDLE);
    assign trig_if.sorted_cnt = sorted_q;
    assign trig_if.missed_cnt = missed_q;

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// Droplet sort decision stage on the CHA fluorescence signal: segments droplet
// events, measures peak and width, and requests a sort pulse for qualifying ones.
module red_pitaya_fads_sorter
    import red_pitaya_fads_pkg::*;
#(
    parameter int WW = FADS_WW,
    parameter int DW = FADS_DW,
    parameter int CW = FADS_CW
) (
    input  logic                adc_clk_i,
    input  logic                adc_rstn_i,
    input  logic signed [13:0]  adc_a_i,
    input  logic                enable_i,
    input  logic signed [13:0]  low_thr_i,
    input  logic signed [13:0]  sort_thr_i,
    input  logic [WW-1:0]       min_width_i,
    input  logic [WW-1:0]       max_width_i,
    input  logic [DW-1:0]       delay_i,
    input  logic [DW-1:0]       pulse_len_i,
    output logic                sort_trig_o,
    output logic                busy_o,
    output logic signed [13:0]  last_peak_o,
    output logic [WW-1:0]       last_width_o,
    output logic [CW-1:0]       droplet_cnt_o,
    output logic [CW-1:0]       sorted_cnt_o,
    output logic [CW-1:0]       missed_cnt_o
);

    det_state_e         d_state_q, d_state_d;
    logic signed [13:0] s_q, s_d;
    logic signed [13:0] peak_q, peak_d;
    logic signed [13:0] last_peak_q, last_peak_d;
    logic [WW-1:0]      width_q, width_d;
    logic [WW-1:0]      last_width_q, last_width_d;
    logic [CW-1:0]      droplet_cnt_q, droplet_cnt_d;
    logic               above;
    logic               width_ok;
    logic               decision;

    red_pitaya_fads_sorter_if #(.DW(DW), .CW(CW)) trig_if ();

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            d_state_q     <= D_IDLE;
            s_q           <= '0;
            peak_q        <= '0;
            last_peak_q   <= '0;
            width_q       <= '0;
            last_width_q  <= '0;
            droplet_cnt_q <= '0;
        end else begin
            d_state_q     <= d_state_d;
            s_q           <= s_d;
            peak_q        <= peak_d;
            last_peak_q   <= last_peak_d;
            width_q       <= width_d;
            last_width_q  <= last_width_d;
            droplet_cnt_q <= droplet_cnt_d;
        end
    end

    always_comb begin
        s_d           = adc_a_i;
        d_state_d     = d_state_q;
        peak_d        = peak_q;
        last_peak_d   = last_peak_q;
        width_d       = width_q;
        last_width_d  = last_width_q;
        droplet_cnt_d = droplet_cnt_q;
        decision      = 1'b0;
        above         = (s_q > low_thr_i);
        width_ok      = (width_q >= min_width_i) && (width_q <= max_width_i);

        unique case (d_state_q)
            D_IDLE: begin
                if (enable_i && above) begin
                    d_state_d = D_IN;
                    peak_d    = s_q;
                    width_d   = WW'(1);
                end
            end
            D_IN: begin
                if (!enable_i) begin
                    // Disabling mid-droplet throws the partial event away.
                    d_state_d = D_IDLE;
                end else if (above) begin
                    if (width_q != {WW{1'b1}}) width_d = width_q + 1'b1;
                    if (s_q > peak_q) peak_d = s_q;
                end else begin
                    d_state_d     = D_IDLE;
                    last_peak_d   = peak_q;
                    last_width_d  = width_q;
                    droplet_cnt_d = droplet_cnt_q + 1'b1;
                    decision      = (peak_q >= sort_thr_i) && width_ok;
                end
            end
            default: d_state_d = D_IDLE;
        endcase
    end

    assign trig_if.decision  = decision;
    assign trig_if.delay     = delay_i;
    assign trig_if.pulse_len = pulse_len_i;

    red_pitaya_fads_pulse_gen #(.DW(DW), .CW(CW)) u_pulse_gen (
        .clk_i   (adc_clk_i),
        .rstn_i  (adc_rstn_i),
        .trig_if (trig_if)
    );

    assign sort_trig_o   = trig_if.sort_trig;
    assign busy_o        = trig_if.busy;
    assign sorted_cnt_o  = trig_if.sorted_cnt;
    assign missed_cnt_o  = trig_if.missed_cnt;
    assign last_peak_o   = last_peak_q;
    assign last_width_o  = last_width_q;
    assign droplet_cnt_o = droplet_cnt_q;

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// Randomised and directed bench for the FADS sorter with a droplet-level
// reference model feeding expected-result queues checked by a monitor.
module tb_red_pitaya_fads_sorter;

    logic               clk;
    logic               adc_rstn_i;
    logic signed [13:0] adc_a_i;
    logic               enable_i;
    logic signed [13:0] low_thr_i;
    logic signed [13:0] sort_thr_i;
    logic [15:0]        min_width_i;
    logic [15:0]        max_width_i;
    logic [23:0]        delay_i;
    logic [23:0]        pulse_len_i;
    logic               sort_trig_o;
    logic               busy_o;
    logic signed [13:0] last_peak_o;
    logic [15:0]        last_width_o;
    logic [31:0]        droplet_cnt_o;
    logic [31:0]        sorted_cnt_o;
    logic [31:0]        missed_cnt_o;

    red_pitaya_fads_sorter dut (
        .adc_clk_i     (clk),
        .adc_rstn_i    (adc_rstn_i),
        .adc_a_i       (adc_a_i),
        .enable_i      (enable_i),
        .low_thr_i     (low_thr_i),
        .sort_thr_i    (sort_thr_i),
        .min_width_i   (min_width_i),
        .max_width_i   (max_width_i),
        .delay_i       (delay_i),
        .pulse_len_i   (pulse_len_i),
        .sort_trig_o   (sort_trig_o),
        .busy_o        (busy_o),
        .last_peak_o   (last_peak_o),
        .last_width_o  (last_width_o),
        .droplet_cnt_o (droplet_cnt_o),
        .sorted_cnt_o  (sorted_cnt_o),
        .missed_cnt_o  (missed_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int          n_vec;
    int          n_fail;
    longint      cyc;
    logic [63:0] drop_q[$];   // {count, peak[15:0], width[15:0]}
    logic [63:0] pulse_q[$];  // {start edge, length}
    int          m_samp[$];   // samples of the droplet in progress
    bit          m_in;
    int          s_m;
    longint      m_drop, m_sorted, m_missed, free_edge;
    int          base;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Droplet-level reference: a droplet is the run of enabled samples above
    // the presence threshold; it is judged when the first sample at/below it arrives.
    task automatic model_step(input int x, input bit en, input longint e);
        int pk, wd, L;
        if (!m_in) begin
            if (en && x > int'(low_thr_i)) begin
                m_in = 1'b1;
                m_samp.delete();
                m_samp.push_back(x);
            end
        end else if (!en) begin
            m_in = 1'b0;
        end else if (x > int'(low_thr_i)) begin
            m_samp.push_back(x);
        end else begin
            m_in = 1'b0;
            pk = m_samp[0];
            foreach (m_samp[i]) if (m_samp[i] > pk) pk = m_samp[i];
            wd = (m_samp.size() > 65535) ? 65535 : m_samp.size();
            m_drop++;
            drop_q.push_back({32'(m_drop), 16'(pk), 16'(wd)});
            if (pk >= int'(sort_thr_i) && wd >= int'(min_width_i) && wd <= int'(max_width_i)) begin
                if (e > free_edge) begin
                    L = (pulse_len_i == 24'd0) ? 1 : int'(pulse_len_i);
                    pulse_q.push_back({32'(e + longint'(delay_i)), 32'(L)});
                    free_edge = e + longint'(delay_i) + L;
                    m_sorted++;
                end else begin
                    m_missed++;
                end
            end
        end
    endtask

    // Model advances on every active edge using the inputs the DUT sees there.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!adc_rstn_i) begin
                m_in = 1'b0; m_samp.delete(); drop_q.delete(); pulse_q.delete();
                m_drop = 0; m_sorted = 0; m_missed = 0; free_edge = -1; s_m = 0;
            end else begin
                model_step(s_m, enable_i, cyc);
                s_m = int'(adc_a_i);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit          trig_prev;
        logic [31:0] drop_prev;
        longint      rise_cyc;
        logic [63:0] ent;
        trig_prev = 1'b0; drop_prev = '0; rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (adc_rstn_i) begin
                check("busy", busy_o, cyc < free_edge);
                if (sort_trig_o && !trig_prev) rise_cyc = cyc;
                if (!sort_trig_o && trig_prev) begin
                    if (pulse_q.size() == 0) begin
                        check("pulse_unexpected_len", cyc - rise_cyc, 0);
                    end else begin
                        ent = pulse_q.pop_front();
                        check("pulse_start", rise_cyc, longint'(ent[63:32]));
                        check("pulse_len", cyc - rise_cyc, longint'(ent[31:0]));
                    end
                end
                if (droplet_cnt_o != drop_prev) begin
                    if (drop_q.size() == 0) begin
                        check("droplet_unexpected", droplet_cnt_o, drop_prev);
                    end else begin
                        ent = drop_q.pop_front();
                        check("droplet_cnt", droplet_cnt_o, longint'(ent[63:32]));
                        check("last_peak", last_peak_o, longint'($signed(ent[31:16])));
                        check("last_width", last_width_o, longint'(ent[15:0]));
                    end
                end
            end
            trig_prev = sort_trig_o;
            drop_prev = droplet_cnt_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int x, input bit en);
        @(negedge clk);
        adc_a_i  = 14'(x);
        enable_i = en;
    endtask

    task automatic evt(input int amps[$], input int gap);
        foreach (amps[i]) drive(amps[i], 1'b1);
        repeat (gap) drive(base, 1'b1);
    endtask

    task automatic cfg(input int lo, input int st, input int mn, input int mx,
                       input int dl, input int ln);
        low_thr_i   = 14'(lo);
        sort_thr_i  = 14'(st);
        min_width_i = 16'(mn);
        max_width_i = 16'(mx);
        delay_i     = 24'(dl);
        pulse_len_i = 24'(ln);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a[$];
        longint cnt_before;
        n_vec = 0; n_fail = 0; base = 0;
        adc_rstn_i = 1'b0; adc_a_i = '0; enable_i = 1'b1;
        cfg(100, 500, 3, 10, 5, 4);
        repeat (4) drive(0, 1'b1);
        check("rst_trig", sort_trig_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_peak", last_peak_o, 0);
        check("rst_width", last_width_o, 0);
        check("rst_droplet", droplet_cnt_o, 0);
        check("rst_sorted", sorted_cnt_o, 0);
        check("rst_missed", missed_cnt_o, 0);
        adc_rstn_i = 1'b1;
        repeat (3) drive(0, 1'b1);

        // basic qualifying droplet, then peak and width rejections
        evt('{200, 600, 300, 150}, 20);
        check("t1_sorted", sorted_cnt_o, 1);
        evt('{200, 400, 300, 150}, 10);
        evt('{200, 200, 200, 600, 200, 200, 200, 200, 200, 200, 200, 200}, 10);
        check("t2_sorted", sorted_cnt_o, 1);
        check("t2_droplets", droplet_cnt_o, 3);

        // zero delay, zero length
        cfg(100, 500, 3, 10, 0, 0);
        evt('{200, 600, 300}, 10);

        // second decision while the first pulse is pending
        cfg(100, 500, 3, 10, 50, 4);
        evt('{200, 600, 300, 150}, 16);
        evt('{200, 600, 300, 150}, 70);
        check("t4_missed", missed_cnt_o, 1);
        check("t4_sorted", sorted_cnt_o, 3);

        // enable dropped mid-droplet
        cnt_before = m_drop;
        drive(200, 1'b1); drive(600, 1'b1); drive(300, 1'b0); drive(300, 1'b0);
        drive(0, 1'b0); repeat (10) drive(0, 1'b1);
        check("en_drop_cnt", droplet_cnt_o, cnt_before);

        // reset during the pulse
        cfg(100, 500, 3, 10, 3, 10);
        evt('{200, 600, 300}, 0);
        for (int i = 0; i < 100 && !sort_trig_o; i++) drive(0, 1'b1);
        check("rst_wait_trig", sort_trig_o, 1);
        @(negedge clk); adc_rstn_i = 1'b0; adc_a_i = '0;
        @(negedge clk);
        check("midrst_trig", sort_trig_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_droplet", droplet_cnt_o, 0);
        check("midrst_sorted", sorted_cnt_o, 0);
        check("midrst_missed", missed_cnt_o, 0);
        @(negedge clk); adc_rstn_i = 1'b1;
        repeat (3) drive(0, 1'b1);

        // signed samples below zero
        base = -300;
        repeat (3) drive(base, 1'b1);
        cfg(-200, -100, 3, 10, 2, 3);
        evt('{-150, -50, -120}, 10);
        check("neg_peak", last_peak_o, -50);
        check("neg_sorted", sorted_cnt_o, 1);
        base = 0;
        repeat (3) drive(base, 1'b1);

        // randomised droplets with live config changes
        for (int n = 0; n < 25; n++) begin
            cfg(100, $urandom_range(300, 700), 2, 8, $urandom_range(0, 20), $urandom_range(0, 6));
            a.delete();
            for (int j = 0; j < int'($urandom_range(1, 12)); j++) a.push_back(int'($urandom_range(101, 900)));
            evt(a, $urandom_range(1, 25));
        end
        repeat (40) drive(0, 1'b1);

        // width saturation
        cfg(100, 500, 3, 10, 5, 4);
        repeat (65540) drive(1000, 1'b1);
        repeat (5) drive(0, 1'b1);
        check("sat_width", last_width_o, 65535);

        repeat (80) drive(0, 1'b1);
        check("end_droplet", droplet_cnt_o, m_drop);
        check("end_sorted", sorted_cnt_o, m_sorted);
        check("end_missed", missed_cnt_o, m_missed);
        check("end_trig", sort_trig_o, 0);
        check("end_pulse_q", pulse_q.size(), 0);
        check("end_drop_q", drop_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
